sdram_stream_writer: RTL

- AHB-Lite master that drains a 32-bit valid/ready sample stream into a circular buffer in SDRAM.
- Sits directly upstream of the SDRAM AHB controller slave: it drives that slave's HADDR/HTRANS/HSIZE/HWRITE/HWDATA and consumes HREADY/HRESP.
- Small internal FIFO absorbs SDRAM refresh/activate stalls.
- Status outputs let payload firmware locate the newest data.

---
 rtl/sdram_stream_writer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_stream_writer.sv
// Drains a 32-bit valid/ready stream into a circular SDRAM region through non-pipelined AHB-Lite writes.
// Define SDRAM_WR_TIMEOUT_EN to abort a beat whose data/address phase stalls for TIMEOUT_CYCLES.
module sdram_stream_writer_fifo #(
    parameter int AW = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [31:0]   i_dat,
    output logic [31:0]   o_head,
    output logic [AW:0]   o_level
);
    logic [31:0]   r_mem [0:(2**AW)-1];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_level;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else if (i_flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + 1'b1;
            if (i_pop)  r_rp <= r_rp + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) r_mem[r_wp] <= i_dat;
    end

    assign o_head  = r_mem[r_rp];
    assign o_level = r_level;
endmodule

module sdram_stream_writer #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          REGION_WORDS   = 1024,
    parameter int          FIFO_AW        = 3,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic               HCLK,
    input  logic               HRESETN,
    input  logic               enable,
    input  logic               clear,
    input  logic               s_valid,
    input  logic [31:0]        s_data,
    output logic               s_ready,
    output logic [31:0]        HADDR,
    output logic [1:0]         HTRANS,
    output logic [2:0]         HSIZE,
    output logic               HWRITE,
    output logic [31:0]        HWDATA,
    input  logic               HREADY,
    input  logic [1:0]         HRESP,
    output logic [23:0]        wr_offset,
    output logic               wrapped,
    output logic               err,
    output logic               timeout,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               busy
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_HALT} state_t;

    localparam logic [FIFO_AW:0] DEPTH    = (FIFO_AW+1)'(2**FIFO_AW);
    localparam logic [23:0]      LAST_OFF = 24'(REGION_WORDS - 1);
    localparam logic [1:0]       HT_IDLE  = 2'b00;
    localparam logic [1:0]       HT_NSEQ  = 2'b10;

    state_t      r_state, w_state_nxt;
    logic [23:0] r_off;
    logic        r_wrapped, r_err, r_clr_pend;
    logic [31:0] w_head;
    logic [FIFO_AW:0] w_level;
    logic        w_clr_req, w_clr_apply, w_start, w_addr_done;
    logic        w_beat_ok, w_beat_err, w_to_hit, w_pop, w_push, w_resp_ok;

    assign w_clr_req = clear | r_clr_pend;
    assign w_resp_ok = (HRESP == 2'b00);
    assign w_pop     = w_beat_ok | w_beat_err | w_to_hit;
    assign w_push    = s_valid & s_ready & ~w_clr_apply;

    sdram_stream_writer_fifo #(.AW(FIFO_AW)) u_fifo (
        .i_clk   (HCLK),
        .i_rst_n (HRESETN),
        .i_flush (w_clr_apply),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_dat   (s_data),
        .o_head  (w_head),
        .o_level (w_level)
    );

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_addr_done = 1'b0;
        w_beat_ok   = 1'b0;
        w_beat_err  = 1'b0;
        w_clr_apply = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_clr_req) begin
                    w_clr_apply = 1'b1;
                end else if (enable && (w_level != '0)) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                if (w_to_hit) begin
                    w_state_nxt = S_HALT;
                end else if (HREADY) begin
                    w_addr_done = 1'b1;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_to_hit) begin
                    w_state_nxt = S_HALT;
                end else if (HREADY && w_resp_ok) begin
                    w_beat_ok   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (HREADY) begin
                    w_beat_err  = 1'b1;
                    w_state_nxt = S_HALT;
                end
            end
            default: begin
                if (w_clr_req) begin
                    w_clr_apply = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            HTRANS     <= HT_IDLE;
            HWRITE     <= 1'b0;
            HADDR      <= BASE_ADDR;
            HWDATA     <= '0;
            r_off      <= '0;
            r_wrapped  <= 1'b0;
            r_err      <= 1'b0;
            r_clr_pend <= 1'b0;
        end else begin
            if (w_clr_apply)  r_clr_pend <= 1'b0;
            else if (clear)   r_clr_pend <= 1'b1;
            if (w_start) begin
                HTRANS <= HT_NSEQ;
                HWRITE <= 1'b1;
                HADDR  <= BASE_ADDR + {6'd0, r_off, 2'b00};
            end
            if (w_addr_done || w_to_hit) begin
                HTRANS <= HT_IDLE;
                HWRITE <= 1'b0;
            end
            if (w_addr_done) HWDATA <= w_head;
            if (w_beat_ok) begin
                r_off <= (r_off == LAST_OFF) ? 24'd0 : r_off + 24'd1;
                if (r_off == LAST_OFF) r_wrapped <= 1'b1;
            end
            if (w_beat_err) r_err <= 1'b1;
            // An in-flight beat finishes first; clearing waits for IDLE/HALT.
            if (w_clr_apply) begin
                r_off     <= '0;
                r_wrapped <= 1'b0;
                r_err     <= 1'b0;
            end
        end
    end

`ifdef SDRAM_WR_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] r_to_cnt;
    logic        r_timeout;
    logic        w_in_beat;

    assign w_in_beat = (r_state == S_ADDR) || (r_state == S_DATA);
    assign w_to_hit  = w_in_beat && !HREADY && (r_to_cnt == TO_LAST);

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_clr_apply)   r_timeout <= 1'b0;
            else if (w_to_hit) r_timeout <= 1'b1;
            if (w_in_beat && !HREADY && !w_to_hit) r_to_cnt <= r_to_cnt + 16'd1;
            else                                   r_to_cnt <= '0;
        end
    end
    assign timeout = r_timeout;
`else
    assign w_to_hit = 1'b0;
    // The limit only has meaning when the stall timer is built in.
    assign timeout  = (TIMEOUT_CYCLES < 0);
`endif

    assign HSIZE      = 3'b010;
    assign s_ready    = HRESETN && (w_level != DEPTH);
    assign fifo_level = w_level;
    assign wr_offset  = r_off;
    assign wrapped    = r_wrapped;
    assign err        = r_err;
    assign busy       = (r_state != S_IDLE);
endmodule
